// File: rtl/srt4_host.sv
// Host-side sequencer for the radix-4 SRT divider byte bus: request -> inbus load -> result collect -> response.
// Optional WAIT watchdog enabled by defining SRT4_HOST_TIMEOUT_EN (TIMEOUT_CYCLES exists only then).
`timescale 1ns/1ps
module srt4_host
`ifdef SRT4_HOST_TIMEOUT_EN
  #(parameter int TIMEOUT_CYCLES = 64)
`endif
  (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_dividend,
  input  logic [7:0]  req_divisor,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_quotient,
  output logic [7:0]  rsp_remainder,
  output logic        rsp_dbz,
  output logic        rsp_ovf,
  output logic        rsp_timeout,
  output logic [7:0]  inbus,
  output logic        beginSignal,
  input  logic [7:0]  outbus,
  input  logic        endSignal
);

  typedef enum logic [2:0] {IDLE, SEND_HI, SEND_LO, SEND_DIV, WAIT, GET_REM, RESP} state_t;

  state_t      state_reg, state_next;
  logic [15:0] dividend_reg, dividend_next;
  logic [7:0]  divisor_reg, divisor_next;
  logic        req_ready_reg, req_ready_next;
  logic        rsp_valid_reg, rsp_valid_next;
  logic [7:0]  quotient_reg, quotient_next;
  logic [7:0]  remainder_reg, remainder_next;
  logic        dbz_reg, dbz_next;
  logic        ovf_reg, ovf_next;
  logic [7:0]  inbus_reg, inbus_next;
  logic        begin_reg, begin_next;
`ifdef SRT4_HOST_TIMEOUT_EN
  logic [7:0]  wait_cnt_reg, wait_cnt_next;
  logic        timeout_reg, timeout_next;
`endif

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_reg     <= IDLE;
      dividend_reg  <= 16'h0000;
      divisor_reg   <= 8'h00;
      req_ready_reg <= 1'b1;
      rsp_valid_reg <= 1'b0;
      quotient_reg  <= 8'h00;
      remainder_reg <= 8'h00;
      dbz_reg       <= 1'b0;
      ovf_reg       <= 1'b0;
      inbus_reg     <= 8'h00;
      begin_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      dividend_reg  <= dividend_next;
      divisor_reg   <= divisor_next;
      req_ready_reg <= req_ready_next;
      rsp_valid_reg <= rsp_valid_next;
      quotient_reg  <= quotient_next;
      remainder_reg <= remainder_next;
      dbz_reg       <= dbz_next;
      ovf_reg       <= ovf_next;
      inbus_reg     <= inbus_next;
      begin_reg     <= begin_next;
    end
  end

`ifdef SRT4_HOST_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wait_cnt_reg <= 8'h00;
      timeout_reg  <= 1'b0;
    end else begin
      wait_cnt_reg <= wait_cnt_next;
      timeout_reg  <= timeout_next;
    end
  end
`endif

  // Outputs are registered: each *_next is the value seen during the state being entered.
  always_comb begin
    state_next     = state_reg;
    dividend_next  = dividend_reg;
    divisor_next   = divisor_reg;
    req_ready_next = req_ready_reg;
    rsp_valid_next = rsp_valid_reg;
    quotient_next  = quotient_reg;
    remainder_next = remainder_reg;
    dbz_next       = dbz_reg;
    ovf_next       = ovf_reg;
    inbus_next     = 8'h00;
    begin_next     = 1'b0;
`ifdef SRT4_HOST_TIMEOUT_EN
    wait_cnt_next  = wait_cnt_reg;
    timeout_next   = timeout_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (req_valid && req_ready_reg) begin
          dividend_next  = req_dividend;
          divisor_next   = req_divisor;
          req_ready_next = 1'b0;
          dbz_next       = 1'b0;
          ovf_next       = 1'b0;
`ifdef SRT4_HOST_TIMEOUT_EN
          timeout_next   = 1'b0;
`endif
          if (req_divisor == 8'h00) begin
            dbz_next       = 1'b1;
            quotient_next  = 8'hFF;
            remainder_next = 8'h00;
            rsp_valid_next = 1'b1;
            state_next     = RESP;
          end else if (req_dividend[15:8] >= req_divisor) begin
            ovf_next       = 1'b1;
            quotient_next  = 8'hFF;
            remainder_next = 8'h00;
            rsp_valid_next = 1'b1;
            state_next     = RESP;
          end else begin
            begin_next = 1'b1;
            inbus_next = req_dividend[15:8];
            state_next = SEND_HI;
          end
        end
      end
      SEND_HI: begin
        inbus_next = dividend_reg[7:0];
        state_next = SEND_LO;
      end
      SEND_LO: begin
        inbus_next = divisor_reg;
        state_next = SEND_DIV;
      end
      SEND_DIV: begin
`ifdef SRT4_HOST_TIMEOUT_EN
        wait_cnt_next = 8'h00;
`endif
        state_next = WAIT;
      end
      WAIT: begin
        if (endSignal) begin
          quotient_next = outbus;
          state_next    = GET_REM;
        end
`ifdef SRT4_HOST_TIMEOUT_EN
        // endSignal on the limit cycle takes the branch above, so it wins over the watchdog
        else if (wait_cnt_reg == 8'(TIMEOUT_CYCLES - 1)) begin
          timeout_next   = 1'b1;
          quotient_next  = 8'hFF;
          remainder_next = 8'h00;
          rsp_valid_next = 1'b1;
          state_next     = RESP;
        end else begin
          wait_cnt_next = wait_cnt_reg + 8'd1;
        end
`endif
      end
      GET_REM: begin
        remainder_next = outbus;
        rsp_valid_next = 1'b1;
        state_next     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          req_ready_next = 1'b1;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign req_ready     = req_ready_reg;
  assign rsp_valid     = rsp_valid_reg;
  assign rsp_quotient  = quotient_reg;
  assign rsp_remainder = remainder_reg;
  assign rsp_dbz       = dbz_reg;
  assign rsp_ovf       = ovf_reg;
  assign inbus         = inbus_reg;
  assign beginSignal   = begin_reg;
`ifdef SRT4_HOST_TIMEOUT_EN
  assign rsp_timeout   = timeout_reg;
`else
  assign rsp_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_srt4_host.sv
// Directed self-checking bench for srt4_host; the divider side is driven by hand from each test task.
`timescale 1ns/1ps
module tb_srt4_host;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_dividend;
  logic [7:0]  req_divisor;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_quotient;
  logic [7:0]  rsp_remainder;
  logic        rsp_dbz;
  logic        rsp_ovf;
  logic        rsp_timeout;
  logic [7:0]  inbus;
  logic        beginSignal;
  logic [7:0]  outbus;
  logic        endSignal;

  int checks = 0;
  int errors = 0;
  int begin_count = 0;

  srt4_host dut (
    .clk(clk), .rst_b(rst_b),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .rsp_dbz(rsp_dbz), .rsp_ovf(rsp_ovf), .rsp_timeout(rsp_timeout),
    .inbus(inbus), .beginSignal(beginSignal),
    .outbus(outbus), .endSignal(endSignal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (beginSignal === 1'b1) begin_count++;

  // Starts and ends on a negedge in IDLE; endSignal is presented in WAIT cycle number wait_cycles.
  task automatic test_divide(input logic [15:0] dd, input logic [7:0] dv,
                             input logic [7:0] q, input logic [7:0] r, input int wait_cycles);
    int b0;
    b0 = begin_count;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL div_idle_ready: got %b expected 1", req_ready); end
    req_valid = 1'b1; req_dividend = dd; req_divisor = dv;
    @(negedge clk); req_valid = 1'b0;
    checks++; if (beginSignal !== 1'b1 || inbus !== dd[15:8] || req_ready !== 1'b0) begin
      errors++; $display("FAIL div_send_hi: begin=%b inbus=%h ready=%b expected 1 %h 0", beginSignal, inbus, req_ready, dd[15:8]); end
    @(negedge clk);
    checks++; if (beginSignal !== 1'b0 || inbus !== dd[7:0]) begin
      errors++; $display("FAIL div_send_lo: begin=%b inbus=%h expected 0 %h", beginSignal, inbus, dd[7:0]); end
    @(negedge clk);
    checks++; if (beginSignal !== 1'b0 || inbus !== dv) begin
      errors++; $display("FAIL div_send_div: begin=%b inbus=%h expected 0 %h", beginSignal, inbus, dv); end
    @(negedge clk);
    checks++; if (inbus !== 8'h00 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL div_wait: inbus=%h valid=%b expected 00 0", inbus, rsp_valid); end
    repeat (wait_cycles - 1) @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL div_wait_end: valid=%b expected 0", rsp_valid); end
    endSignal = 1'b1; outbus = q;
    @(negedge clk); endSignal = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL div_get_rem: valid=%b expected 0", rsp_valid); end
    outbus = r;
    @(negedge clk); outbus = 8'h00;
    checks++; if (rsp_valid !== 1'b1 || rsp_quotient !== q || rsp_remainder !== r ||
                  rsp_dbz !== 1'b0 || rsp_ovf !== 1'b0 || rsp_timeout !== 1'b0) begin
      errors++; $display("FAIL div_rsp: valid=%b q=%h r=%h dbz=%b ovf=%b to=%b expected 1 %h %h 0 0 0",
                         rsp_valid, rsp_quotient, rsp_remainder, rsp_dbz, rsp_ovf, rsp_timeout, q, r); end
    checks++; if (begin_count !== b0 + 1) begin errors++; $display("FAIL div_begin_pulses: got %0d expected %0d", begin_count - b0, 1); end
    rsp_ready = 1'b1;
    @(negedge clk); rsp_ready = 1'b0;
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL div_release: ready=%b valid=%b expected 1 0", req_ready, rsp_valid); end
    $display("divide %h / %h -> q=%h r=%h", dd, dv, rsp_quotient, rsp_remainder);
  endtask

  task automatic test_error(input logic [15:0] dd, input logic [7:0] dv, input logic exp_dbz, input logic exp_ovf);
    int b0;
    b0 = begin_count;
    req_valid = 1'b1; req_dividend = dd; req_divisor = dv;
    @(negedge clk); req_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_dbz !== exp_dbz || rsp_ovf !== exp_ovf || rsp_quotient !== 8'hFF ||
                  rsp_remainder !== 8'h00 || req_ready !== 1'b0 || inbus !== 8'h00) begin
      errors++; $display("FAIL err_rsp: valid=%b dbz=%b ovf=%b q=%h r=%h ready=%b inbus=%h expected 1 %b %b ff 00 0 00",
                         rsp_valid, rsp_dbz, rsp_ovf, rsp_quotient, rsp_remainder, req_ready, inbus, exp_dbz, exp_ovf); end
    rsp_ready = 1'b1;
    @(negedge clk); rsp_ready = 1'b0;
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || begin_count !== b0) begin
      errors++; $display("FAIL err_release: ready=%b valid=%b begins=%0d expected 1 0 0", req_ready, rsp_valid, begin_count - b0); end
    $display("error %h / %h -> dbz=%b ovf=%b", dd, dv, rsp_dbz, rsp_ovf);
  endtask

  task automatic test_reset();
    rst_b = 1'b0; req_valid = 1'b0; req_dividend = '0; req_divisor = '0;
    rsp_ready = 1'b0; outbus = '0; endSignal = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || beginSignal !== 1'b0 || inbus !== 8'h00 ||
                  rsp_quotient !== 8'h00 || rsp_remainder !== 8'h00 || rsp_dbz !== 1'b0 || rsp_ovf !== 1'b0 || rsp_timeout !== 1'b0) begin
      errors++; $display("FAIL reset_state: ready=%b valid=%b begin=%b inbus=%h q=%h r=%h dbz=%b ovf=%b to=%b expected 1 0 0 00 00 00 0 0 0",
                         req_ready, rsp_valid, beginSignal, inbus, rsp_quotient, rsp_remainder, rsp_dbz, rsp_ovf, rsp_timeout); end
    rst_b = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release: ready=%b valid=%b expected 1 0", req_ready, rsp_valid); end
    $display("reset done");
  endtask

  task automatic test_backpressure();
    int b0;
    b0 = begin_count;
    req_valid = 1'b1; req_dividend = 16'hFF00; req_divisor = 8'h01;
    @(negedge clk);
    req_dividend = 16'h0100; req_divisor = 8'h02;
    for (int i = 0; i < 5; i++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_ovf !== 1'b1 || rsp_dbz !== 1'b0 || rsp_quotient !== 8'hFF ||
                    rsp_remainder !== 8'h00 || req_ready !== 1'b0 || beginSignal !== 1'b0 || inbus !== 8'h00) begin
        errors++; $display("FAIL bp_hold[%0d]: valid=%b ovf=%b dbz=%b q=%h r=%h ready=%b begin=%b inbus=%h expected 1 1 0 ff 00 0 0 00",
                           i, rsp_valid, rsp_ovf, rsp_dbz, rsp_quotient, rsp_remainder, req_ready, beginSignal, inbus); end
      @(negedge clk);
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk); rsp_ready = 1'b0;
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || begin_count !== b0) begin
      errors++; $display("FAIL bp_release: ready=%b valid=%b begins=%0d expected 1 0 0", req_ready, rsp_valid, begin_count - b0); end
    $display("backpressure released");
  endtask

  task automatic test_reset_in_wait();
    req_valid = 1'b1; req_dividend = 16'h00FF; req_divisor = 8'h10;
    @(negedge clk); req_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (req_ready !== 1'b0 || inbus !== 8'h00) begin
      errors++; $display("FAIL rw_in_wait: ready=%b inbus=%h expected 0 00", req_ready, inbus); end
    #2 rst_b = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || beginSignal !== 1'b0 || inbus !== 8'h00 ||
                  rsp_quotient !== 8'h00 || rsp_remainder !== 8'h00 || rsp_dbz !== 1'b0 || rsp_ovf !== 1'b0) begin
      errors++; $display("FAIL rw_async: ready=%b valid=%b begin=%b inbus=%h q=%h r=%h dbz=%b ovf=%b expected 1 0 0 00 00 00 0 0",
                         req_ready, rsp_valid, beginSignal, inbus, rsp_quotient, rsp_remainder, rsp_dbz, rsp_ovf); end
    @(negedge clk); rst_b = 1'b1;
    @(negedge clk);
    $display("reset in wait done");
    test_divide(16'h00FF, 8'h10, 8'h0F, 8'h0F, 2);
  endtask

  task automatic test_timeout();
`ifdef SRT4_HOST_TIMEOUT_EN
    req_valid = 1'b1; req_dividend = 16'h0123; req_divisor = 8'h45;
    @(negedge clk); req_valid = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 1; i < 64; i++) begin
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL to_early[%0d]: valid=%b expected 0", i, rsp_valid); end
      @(negedge clk);
    end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL to_cycle64: valid=%b expected 0", rsp_valid); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b1 || rsp_quotient !== 8'hFF || rsp_remainder !== 8'h00 ||
                  rsp_dbz !== 1'b0 || rsp_ovf !== 1'b0) begin
      errors++; $display("FAIL to_rsp: valid=%b to=%b q=%h r=%h dbz=%b ovf=%b expected 1 1 ff 00 0 0",
                         rsp_valid, rsp_timeout, rsp_quotient, rsp_remainder, rsp_dbz, rsp_ovf); end
    rsp_ready = 1'b1;
    @(negedge clk); rsp_ready = 1'b0;
    $display("timeout response seen to=%b", rsp_timeout);
    test_divide(16'h03E8, 8'h07, 8'h8E, 8'h06, 64);
`else
    test_divide(16'h03E8, 8'h07, 8'h8E, 8'h06, 80);
`endif
  endtask

  initial begin
    test_reset();
    test_divide(16'h03E8, 8'h07, 8'h8E, 8'h06, 3);
    test_error(16'h1234, 8'h00, 1'b1, 1'b0);
    test_error(16'h0500, 8'h00, 1'b1, 1'b0);
    test_error(16'h0700, 8'h07, 1'b0, 1'b1);
    test_divide(16'h0600, 8'h07, 8'hDB, 8'h03, 1);
    test_divide(16'h06FF, 8'h07, 8'hFF, 8'h06, 5);
    test_backpressure();
    test_reset_in_wait();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/srt4_host.md
Name: srt4_host

Overview:
- Host-side sequencer for the radix-4 SRT divider's 8-bit byte-serial bus.
- Accepts a 16-bit dividend and 8-bit divisor on a valid/ready request port, then drives the inbus load sequence with beginSignal.
- Waits for endSignal, collects quotient and remainder from outbus, and returns them on a valid/ready response port.
- Screens divide-by-zero and quotient overflow locally, without starting the divider.

Parameters:
- TIMEOUT_CYCLES, 64: WAIT-state watchdog limit; used only with SRT4_HOST_TIMEOUT_EN.

Ports:
- clk  input  1  clock, all state on rising edge
- rst_b  input  1  asynchronous reset, active low
- req_valid  input  1  request present
- req_ready  output  1  host can accept a request
- req_dividend  input  16  dividend
- req_divisor  input  8  divisor
- rsp_valid  output  1  result present
- rsp_ready  input  1  consumer takes result
- rsp_quotient  output  8  quotient
- rsp_remainder  output  8  remainder
- rsp_dbz  output  1  divisor was zero
- rsp_ovf  output  1  quotient would exceed 8 bits
- rsp_timeout  output  1  watchdog abort; tied 0 without the feature
- inbus  output  8  byte to divider
- beginSignal  output  1  start strobe to divider
- outbus  input  8  byte from divider
- endSignal  input  1  divider result strobe

Behaviour:
- Clock and reset: one clock, clk. Reset rst_b is asynchronous, active low.
- Reset state: every output 0 except req_ready = 1; state IDLE; all latches cleared.
- Outputs are registered.

State machine:
- IDLE: req_ready = 1. On req_valid & req_ready, latch both operands.
  - If divisor == 0: set dbz, go to RESP.
  - Else if dividend[15:8] >= divisor: set ovf, go to RESP.
  - Else go to SEND_HI.
  - dbz takes priority over ovf.
- SEND_HI: beginSignal = 1, inbus = dividend[15:8]. Next state SEND_LO.
- SEND_LO: beginSignal = 0, inbus = dividend[7:0]. Next state SEND_DIV.
- SEND_DIV: inbus = divisor. Next state WAIT.
- WAIT: inbus = 0. On endSignal = 1, capture outbus as quotient, go to GET_REM.
- GET_REM: capture outbus as remainder unconditionally, go to RESP.
- RESP: rsp_valid = 1, all rsp_* fields held stable. On rsp_ready, clear rsp_valid and go to IDLE. req_ready returns to 1 in the following cycle.

Timing and rules:
- beginSignal is exactly a one-cycle pulse, coincident with the first bus byte.
- Valid path latency: the SEND_HI cycle immediately follows the accept cycle. rsp_valid rises two cycles after endSignal is sampled.
- Error path: dbz or ovf results appear with rsp_valid in the cycle after accept. Quotient = 8'hFF, remainder = 8'h00, beginSignal never asserted.
- req_ready is 0 in every state except IDLE. Only one transaction is in flight.
- endSignal is ignored outside WAIT.
- Reset mid-operation: everything drops asynchronously to reset values. The divider must also be reset by the same rst_b.
- Arithmetic: unsigned only. The overflow check is an unsigned 8-bit compare.

Optional Feature:
- Macro: SRT4_HOST_TIMEOUT_EN.
- With the macro: an 8-bit counter clears on entry to WAIT and increments each WAIT cycle. When the count reaches TIMEOUT_CYCLES without endSignal, go to RESP with rsp_timeout = 1, quotient = 8'hFF, remainder = 8'h00. If endSignal arrives on the same cycle the limit is reached, endSignal wins.
- Without the macro: no counter is built, WAIT lasts indefinitely, and rsp_timeout is constant 0.

Test Plan:
- Normal divide: dividend 0x03E8, divisor 0x07, divider model answers endSignal with 0x8E then 0x06 → inbus shows 0x03, 0xE8, 0x07 on consecutive cycles. beginSignal is high only with 0x03. rsp: quotient 0x8E, remainder 0x06, all flags 0.
- Divide by zero: dividend 0x1234, divisor 0x00 → rsp_valid in the cycle after accept, dbz = 1, quotient 0xFF, remainder 0x00, beginSignal never high.
- Overflow: dividend 0x0700, divisor 0x07 → ovf = 1, dbz = 0, no bus activity. Dividend 0x0600, divisor 0x07 → normal transaction.
- Backpressure: rsp_ready held 0 for 5 cycles in RESP → rsp fields stable, req_ready 0, a new req_valid is ignored. After rsp_ready = 1, req_ready = 1 in the following cycle.
- Reset in WAIT: assert rst_b = 0 mid-wait → outputs return to reset values immediately. A later request 0x00FF / 0x10 completes with quotient 0x0F, remainder 0x0F.
- Timeout (SRT4_HOST_TIMEOUT_EN, TIMEOUT_CYCLES = 64): endSignal never asserted → rsp_valid after 64 WAIT cycles with rsp_timeout = 1. With endSignal on cycle 64, a normal result is returned with timeout = 0.
